// File: rtl/qgemm_scale_sched_pkg.sv
// Shared definitions for the quantized-GEMM scale sequencer: FSM encoding,
// default widths and a small elaboration-time helper.
package qgemm_scale_sched_pkg;

  localparam int CNT_W_DEF   = 8;
  localparam int STALL_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT_ACC = 3'd2,
    ST_DEQ      = 3'd3,
    ST_FIN      = 3'd4
  } state_t;

  // Ceiling log2 for sizing indices from element counts.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/qgemm_scale_sched_if.sv
// Bundle of every handshake between the scale sequencer and its neighbours:
// command front end, accumulator array, scale FIFO read port and dequant.
// The master modport is the sequencer; slave is the surrounding datapath.
interface qgemm_scale_sched_if
  import qgemm_scale_sched_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int STALL_W = STALL_W_DEF
);

  logic               cmd_valid_i;
  logic               cmd_ready_o;
  logic [CNT_W-1:0]   cmd_ktiles_i;
  logic [CNT_W-1:0]   cmd_otiles_i;
  logic               abort_i;
  logic               acc_start_o;
  logic               acc_first_o;
  logic               acc_last_o;
  logic               acc_done_i;
  logic               fifo_rd_valid_i;
  logic               fifo_rd_ready_o;
  logic               fifo_flush_o;
  logic               deq_valid_o;
  logic               deq_ready_i;
  logic               busy_o;
  logic               done_o;
  logic               aborted_o;
  logic [STALL_W-1:0] stall_cnt_o;

  modport master (
    input  cmd_valid_i, cmd_ktiles_i, cmd_otiles_i, abort_i,
           acc_done_i, fifo_rd_valid_i, deq_ready_i,
    output cmd_ready_o, acc_start_o, acc_first_o, acc_last_o,
           fifo_rd_ready_o, fifo_flush_o, deq_valid_o,
           busy_o, done_o, aborted_o, stall_cnt_o
  );

  modport slave (
    output cmd_valid_i, cmd_ktiles_i, cmd_otiles_i, abort_i,
           acc_done_i, fifo_rd_valid_i, deq_ready_i,
    input  cmd_ready_o, acc_start_o, acc_first_o, acc_last_o,
           fifo_rd_ready_o, fifo_flush_o, deq_valid_o,
           busy_o, done_o, aborted_o, stall_cnt_o
  );

endinterface

// File: rtl/qgemm_sat_cnt.sv
// Generic saturating up-counter with synchronous clear; clear wins over
// increment, and the count sticks at all-ones instead of wrapping.
module qgemm_sat_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] cnt_max = '1;

  // Count register: reset/clear to zero, otherwise step until saturated.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != cnt_max)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/qgemm_scale_sched.sv
// Tile sequencer: runs K accumulate passes per output tile, then hands one
// scale-FIFO entry to dequant per tile, and reports done or aborted.
module qgemm_scale_sched
  import qgemm_scale_sched_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int STALL_W = STALL_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  qgemm_scale_sched_if.master bus
);

  localparam logic [CNT_W-1:0] cnt_one = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] ktiles, otiles, k_idx, o_idx;
  logic [CNT_W-1:0] ktiles_nxt, otiles_nxt, k_idx_nxt, o_idx_nxt;
  logic             k_last, o_last;
  logic             abort_hit, abort_q;
  logic             stall_clr, stall_inc;
  logic             cmd_ready, acc_start, acc_first, acc_last;
  logic             deq_valid, fifo_rd_ready, busy, done;

  // Zero counts divert to FIN at acceptance, so these never see ktiles-1 wrap.
  assign k_last    = (k_idx == ktiles - cnt_one);
  assign o_last    = (o_idx == otiles - cnt_one);
  assign abort_hit = bus.abort_i && (state != ST_IDLE);

  // Next-state, counter updates and state-decoded outputs.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned, which would infer a latch.
    state_nxt     = state;
    ktiles_nxt    = ktiles;
    otiles_nxt    = otiles;
    k_idx_nxt     = k_idx;
    o_idx_nxt     = o_idx;
    stall_clr     = 1'b0;
    stall_inc     = 1'b0;
    cmd_ready     = !rst && (state == ST_IDLE);
    acc_start     = !rst && (state == ST_ISSUE);
    acc_first     = acc_start && (k_idx == '0);
    acc_last      = acc_start && k_last;
    busy          = !rst && (state != ST_IDLE);
    done          = !rst && (state == ST_FIN) && !bus.abort_i;
    // Dequant handshake is combinational; an abort or reset suppresses the pop.
    deq_valid     = !rst && !bus.abort_i && (state == ST_DEQ) && bus.fifo_rd_valid_i;
    fifo_rd_ready = deq_valid && bus.deq_ready_i;

    unique case (state)
      ST_IDLE: begin
        if (bus.cmd_valid_i) begin
          ktiles_nxt = bus.cmd_ktiles_i;
          otiles_nxt = bus.cmd_otiles_i;
          k_idx_nxt  = '0;
          o_idx_nxt  = '0;
          stall_clr  = 1'b1;
          if ((bus.cmd_ktiles_i == '0) || (bus.cmd_otiles_i == '0)) state_nxt = ST_FIN;
          else                                                      state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT_ACC;
      ST_WAIT_ACC: begin
        if (bus.acc_done_i) begin
          if (k_last) begin
            state_nxt = ST_DEQ;
          end else begin
            k_idx_nxt = k_idx + cnt_one;
            state_nxt = ST_ISSUE;
          end
        end
      end
      ST_DEQ: begin
        stall_inc = !bus.fifo_rd_valid_i;
        if (fifo_rd_ready) begin
          k_idx_nxt = '0;
          if (o_last) begin
            state_nxt = ST_FIN;
          end else begin
            o_idx_nxt = o_idx + cnt_one;
            state_nxt = ST_ISSUE;
          end
        end
      end
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    if (abort_hit) state_nxt = ST_IDLE;
  end

  // State, tile counters and the registered abort pulse.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      state   <= ST_IDLE;
      ktiles  <= '0;
      otiles  <= '0;
      k_idx   <= '0;
      o_idx   <= '0;
      abort_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      ktiles  <= ktiles_nxt;
      otiles  <= otiles_nxt;
      k_idx   <= k_idx_nxt;
      o_idx   <= o_idx_nxt;
      abort_q <= abort_hit;
    end
  end

  qgemm_sat_cnt #(.WIDTH(STALL_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (stall_clr),
    .inc (stall_inc),
    .cnt (bus.stall_cnt_o)
  );

  assign bus.cmd_ready_o     = cmd_ready;
  assign bus.acc_start_o     = acc_start;
  assign bus.acc_first_o     = acc_first;
  assign bus.acc_last_o      = acc_last;
  assign bus.deq_valid_o     = deq_valid;
  assign bus.fifo_rd_ready_o = fifo_rd_ready;
  assign bus.fifo_flush_o    = abort_q && !rst;
  assign bus.aborted_o       = abort_q && !rst;
  assign bus.busy_o          = busy;
  assign bus.done_o          = done;

endmodule

// File: tb/tb_qgemm_scale_sched.sv
// Self-checking bench for qgemm_scale_sched: directed scenarios plus random
// jobs scored against an event-level model of the job (expected pass flags,
// pop count, done timing and starvation cycles).
module tb_qgemm_scale_sched;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  logic       sat_clr, sat_inc;
  logic [2:0] sat_cnt;

  always #5 clk = ~clk;

  qgemm_scale_sched_if bus ();

  qgemm_scale_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  qgemm_sat_cnt #(.WIDTH(3)) u_sat (
    .clk (clk),
    .rst (rst),
    .clr (sat_clr),
    .inc (sat_inc),
    .cnt (sat_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {cmd_ready, acc_start, acc_first, acc_last, fifo_rd_ready, fifo_flush, deq_valid, busy, done, aborted}
  function automatic logic [9:0] outs();
    return {bus.cmd_ready_o, bus.acc_start_o, bus.acc_first_o, bus.acc_last_o,
            bus.fifo_rd_ready_o, bus.fifo_flush_o, bus.deq_valid_o,
            bus.busy_o, bus.done_o, bus.aborted_o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one job. Accumulator answers lat cycles after each start. In each
  // DEQ phase the FIFO is empty for 'starve' cycles, then dequant holds ready
  // low for 'hold' more cycles; rnd adds random gaps on both.
  task automatic run_job(input string tag, input int kt, input int ot, input int lat,
                         input int starve, input int hold, input bit rnd);
    bit exp_first[$];
    bit exp_last[$];
    int n_start = 0, n_pop = 0, n_done = 0, stall_exp = 0;
    int k_done = 0, cd = 0, deq_cyc = 0, cyc = 0, done_cyc = -2, last_pop_cyc = -1;
    bit pend = 0, in_deq = 0, deq_next = 0, finished = 0;
    bit fv, dr, e_first, e_last;

    for (int o = 0; o < ot; o++)
      for (int k = 0; k < kt; k++) begin
        exp_first.push_back(k == 0);
        exp_last.push_back(k == kt - 1);
      end

    tick();
    bus.cmd_valid_i  = 1'b1;
    bus.cmd_ktiles_i = 8'(kt);
    bus.cmd_otiles_i = 8'(ot);
    bus.acc_done_i   = 1'b0;
    @(negedge clk);
    check({tag, "/cmd_ready"}, bus.cmd_ready_o, 1);

    while (!finished && cyc < 2000) begin
      tick();
      bus.cmd_valid_i  = 1'b0;
      bus.cmd_ktiles_i = 8'($urandom);
      bus.cmd_otiles_i = 8'($urandom);
      if (deq_next) begin
        in_deq   = 1'b1;
        deq_next = 1'b0;
        deq_cyc  = 0;
      end
      bus.acc_done_i = 1'b0;
      if (pend) begin
        cd--;
        if (cd == 0) begin
          bus.acc_done_i = 1'b1;
          pend = 1'b0;
          k_done++;
          if (k_done == kt) begin
            deq_next = 1'b1;
            k_done   = 0;
          end
        end
      end
      if (in_deq) begin
        fv = (deq_cyc >= starve) && (!rnd || ($urandom_range(99) < 70));
        dr = (deq_cyc >= starve + hold) && (!rnd || ($urandom_range(99) < 70));
      end else begin
        fv = 1'b1;
        dr = 1'b1;
      end
      bus.fifo_rd_valid_i = fv;
      bus.deq_ready_i     = dr;

      @(negedge clk);
      if (bus.acc_start_o) begin
        check({tag, "/start_in_wrong_phase"}, 32'(pend || in_deq), 0);
        n_start++;
        if (exp_first.size() == 0) begin
          check({tag, "/extra_start"}, n_start, kt * ot);
        end else begin
          e_first = exp_first.pop_front();
          e_last  = exp_last.pop_front();
          check({tag, "/acc_first"}, bus.acc_first_o, e_first);
          check({tag, "/acc_last"}, bus.acc_last_o, e_last);
        end
        pend = 1'b1;
        cd   = lat;
      end
      if (in_deq) begin
        check({tag, "/deq_valid"}, bus.deq_valid_o, fv);
        check({tag, "/pop"}, bus.fifo_rd_ready_o, fv & dr);
        if (!fv) stall_exp++;
        deq_cyc++;
        if (fv && dr) begin
          in_deq = 1'b0;
          n_pop++;
          if (n_pop == ot) last_pop_cyc = cyc;
        end
      end else begin
        check({tag, "/bus_outside_deq"}, {bus.deq_valid_o, bus.fifo_rd_ready_o}, 2'b00);
      end
      check({tag, "/ready_busy_flush_abort"},
            {bus.cmd_ready_o, bus.busy_o, bus.fifo_flush_o, bus.aborted_o}, 4'b0100);
      if (bus.done_o) begin
        n_done++;
        done_cyc = cyc;
        finished = 1'b1;
      end
      cyc++;
    end

    check({tag, "/finished_in_budget"}, finished, 1);
    check({tag, "/start_count"}, n_start, kt * ot);
    check({tag, "/pop_count"}, n_pop, (kt == 0 || ot == 0) ? 0 : ot);
    check({tag, "/done_count"}, n_done, 1);
    check({tag, "/done_cycle"}, done_cyc, last_pop_cyc + 1);
    check({tag, "/stall_cnt"}, bus.stall_cnt_o, stall_exp);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst                 = 1'b1;
    sat_clr             = 1'b0;
    sat_inc             = 1'b0;
    bus.cmd_valid_i     = 1'b0;
    bus.cmd_ktiles_i    = '0;
    bus.cmd_otiles_i    = '0;
    bus.abort_i         = 1'b0;
    bus.acc_done_i      = 1'b0;
    bus.fifo_rd_valid_i = 1'b0;
    bus.deq_ready_i     = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset/outs", outs(), 10'b0);
    check("reset/stall", bus.stall_cnt_o, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset/idle_outs", outs(), 10'b1000000000);

    // Saturating counter on its own, 3 bits wide.
    sat_inc = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      @(negedge clk);
      check("sat/count", sat_cnt, (i < 7) ? i : 7);
    end
    tick();
    sat_inc = 1'b0;
    sat_clr = 1'b1;
    @(negedge clk);
    check("sat/clear", sat_cnt, 7);
    tick();
    sat_clr = 1'b0;
    @(negedge clk);
    check("sat/cleared", sat_cnt, 0);

    // Directed jobs.
    run_job("basic", 3, 2, 4, 0, 0, 1'b0);
    run_job("starve", 1, 1, 2, 7, 0, 1'b0);
    run_job("backpressure", 2, 1, 1, 0, 5, 1'b0);
    run_job("zero_k", 0, 5, 1, 0, 0, 1'b0);
    run_job("zero_o", 4, 0, 1, 0, 0, 1'b0);

    // Abort in WAIT_ACC of tile 1 (of 3), FIFO and dequant always ready.
    tick();
    bus.cmd_valid_i     = 1'b1;
    bus.cmd_ktiles_i    = 8'd2;
    bus.cmd_otiles_i    = 8'd3;
    bus.fifo_rd_valid_i = 1'b1;
    bus.deq_ready_i     = 1'b1;
    bus.acc_done_i      = 1'b0;
    @(negedge clk);
    check("abort/cmd_ready", bus.cmd_ready_o, 1);
    tick();
    bus.cmd_valid_i = 1'b0;
    @(negedge clk);
    check("abort/t0k0_flags", {bus.acc_start_o, bus.acc_first_o, bus.acc_last_o}, 3'b110);
    tick();
    bus.acc_done_i = 1'b1;
    tick();
    bus.acc_done_i = 1'b0;
    @(negedge clk);
    check("abort/t0k1_flags", {bus.acc_start_o, bus.acc_first_o, bus.acc_last_o}, 3'b101);
    tick();
    bus.acc_done_i = 1'b1;
    tick();
    bus.acc_done_i = 1'b0;
    @(negedge clk);
    check("abort/t0_pop", bus.fifo_rd_ready_o, 1);
    tick();
    @(negedge clk);
    check("abort/t1k0_flags", {bus.acc_start_o, bus.acc_first_o, bus.acc_last_o}, 3'b110);
    tick();
    bus.abort_i = 1'b1;
    @(negedge clk);
    check("abort/abort_cycle_outs", outs(), 10'b0000000100);
    tick();
    bus.abort_i    = 1'b0;
    bus.acc_done_i = 1'b1;
    @(negedge clk);
    check("abort/pulse_outs", outs(), 10'b1000010001);
    tick();
    bus.acc_done_i = 1'b0;
    @(negedge clk);
    check("abort/late_done_ignored", outs(), 10'b1000000000);

    // Abort while idle does nothing.
    tick();
    bus.abort_i = 1'b1;
    @(negedge clk);
    check("idle_abort/same_cycle", outs(), 10'b1000000000);
    tick();
    bus.abort_i = 1'b0;
    @(negedge clk);
    check("idle_abort/next_cycle", outs(), 10'b1000000000);

    // Random jobs.
    for (int j = 0; j < 6; j++) begin
      run_job($sformatf("rand%0d", j), int'($urandom_range(4, 1)), int'($urandom_range(3, 1)),
              int'($urandom_range(3, 1)), 0, 0, 1'b1);
    end

    // Reset while parked in DEQ with dequant ready.
    tick();
    bus.cmd_valid_i     = 1'b1;
    bus.cmd_ktiles_i    = 8'd1;
    bus.cmd_otiles_i    = 8'd1;
    bus.fifo_rd_valid_i = 1'b0;
    bus.deq_ready_i     = 1'b1;
    bus.acc_done_i      = 1'b0;
    tick();
    bus.cmd_valid_i = 1'b0;
    tick();
    bus.acc_done_i = 1'b1;
    tick();
    bus.acc_done_i = 1'b0;
    tick();
    @(negedge clk);
    check("rst_deq/parked_outs", outs(), 10'b0000000100);
    check("rst_deq/stall_before", bus.stall_cnt_o, 1);
    tick();
    rst                 = 1'b1;
    bus.fifo_rd_valid_i = 1'b1;
    @(negedge clk);
    check("rst_deq/no_pop", bus.fifo_rd_ready_o, 0);
    tick();
    @(negedge clk);
    check("rst_deq/outs", outs(), 10'b0);
    check("rst_deq/stall", bus.stall_cnt_o, 0);
    tick();
    rst                 = 1'b0;
    bus.fifo_rd_valid_i = 1'b0;
    bus.deq_ready_i     = 1'b0;
    @(negedge clk);
    check("rst_deq/idle_outs", outs(), 10'b1000000000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/qgemm_scale_sched.md
Name: qgemm_scale_sched

Overview:
Tile sequencer for the quantized-GEMM back end. It accepts a job command (K-tiles per output tile, number of output tiles) and drives the accumulator through K passes per output tile. It then releases one FP scale matrix from the scale FIFO into the dequant stage, one FIFO entry per output tile, and reports completion. It sits between the command front end, the accumulator array, the scale FIFO read port and the dequant stage.

Parameters:
CNT_W, 8, width of the K-tile and output-tile counts; values 0 .. 2^CNT_W-1
STALL_W, 16, width of the saturating scale-stall counter

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active high
cmd_valid_i  in  1  job command valid
cmd_ready_o  out  1  job command ready (high only in IDLE)
cmd_ktiles_i  in  CNT_W  K passes per output tile
cmd_otiles_i  in  CNT_W  output tiles in the job
abort_i  in  1  abandon the current job
acc_start_o  out  1  one-cycle pulse: start one accumulate pass
acc_first_o  out  1  valid with acc_start_o: first K pass (clear accumulator)
acc_last_o  out  1  valid with acc_start_o: last K pass
acc_done_i  in  1  one-cycle pulse: accumulate pass finished
fifo_rd_valid_i  in  1  scale FIFO has a head entry (show-ahead)
fifo_rd_ready_o  out  1  pop the scale FIFO head
fifo_flush_o  out  1  one-cycle pulse: flush the scale FIFO
deq_valid_o  out  1  scale and accumulator result offered to dequant
deq_ready_i  in  1  dequant accepts
busy_o  out  1  job in progress
done_o  out  1  one-cycle pulse: job completed normally
aborted_o  out  1  one-cycle pulse: job ended by abort
stall_cnt_o  out  STALL_W  cycles spent in DEQ waiting for fifo_rd_valid_i; saturating

Behaviour:
- Reset (rst high at a clk edge):
  - state=IDLE and both counters 0.
  - Every output low: cmd_ready_o, acc_*, fifo_*, deq_valid_o, busy_o, done_o, aborted_o.
  - stall_cnt_o=0.
  - Reset mid-job drops the job silently. No flush is issued and no done_o/aborted_o pulse.
- FSM states: IDLE, ISSUE, WAIT_ACC, DEQ, FIN.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i, latch ktiles/otiles, clear k_idx, o_idx and stall_cnt_o.
  - If either count is 0, go to FIN. Otherwise go to ISSUE.
- ISSUE:
  - Registered one-cycle acc_start_o, with acc_first_o=(k_idx==0) and acc_last_o=(k_idx==ktiles-1).
  - Next state WAIT_ACC.
  - Acceptance at cycle N gives acc_start_o high at N+1.
- WAIT_ACC: on acc_done_i:
  - If k_idx==ktiles-1, go to DEQ.
  - Otherwise k_idx++ and go to ISSUE.
  - acc_done_i is ignored in every other state.
- DEQ: outputs are combinational.
  - deq_valid_o = fifo_rd_valid_i.
  - fifo_rd_ready_o = fifo_rd_valid_i & deq_ready_i.
  - Exactly one pop per output tile, in the same cycle as the dequant transfer.
  - When fifo_rd_valid_i=0, stall_cnt_o increments and holds at 2^STALL_W-1.
  - On transfer, k_idx=0. If o_idx==otiles-1, go to FIN. Otherwise o_idx++ and go to ISSUE.
- FIN: done_o=1 for one cycle, then IDLE. Back-to-back commands are therefore separated by 1 idle cycle.
- busy_o=1 in every state except IDLE.
- abort_i in any state other than IDLE:
  - Takes priority over every other transition.
  - Next cycle: fifo_flush_o=1 and aborted_o=1 for one cycle, state=IDLE.
  - No pop in the abort cycle, even if DEQ would have transferred.
  - No done_o pulse.
- abort_i in IDLE has no effect.
- Counter arithmetic: CNT_W-bit compares against ktiles-1 and otiles-1. Zero counts never reach these compares, so there is no wrap-around.
- Only one scale entry is in flight. The scale FIFO's full/empty handling is owned by the FIFO; this block never pops when fifo_rd_valid_i=0.

Decomposition:
- Shared qgemm package holds:
  - FSM state encoding constants (IDLE=0, ISSUE=1, WAIT_ACC=2, DEQ=3, FIN=4; 3 bits).
  - Default CNT_W and STALL_W.
  - The clog2 function.
- One natural sub-module: qgemm_sat_cnt, a generic saturating counter with clear and increment, used for stall_cnt_o.
- The FSM and the tile counters stay in the top module.

Test Plan:
- Basic job: ktiles=3, otiles=2, acc_done_i 4 cycles after each start, FIFO valid, deq_ready=1 -> 6 acc_start pulses with first/last flags 1/0, 0/0, 0/1 per tile; 2 pops; done_o once; stall_cnt_o=0.
- Scale starvation: ktiles=1, otiles=1, fifo_rd_valid_i low for 7 cycles in DEQ -> deq_valid_o low and no pop during the wait; stall_cnt_o=7; single pop once valid rises.
- Backpressure: deq_ready_i low for 5 cycles while the FIFO is valid -> deq_valid_o held high, fifo_rd_ready_o low, no state advance; pop in the cycle ready rises.
- Abort during WAIT_ACC on tile 1 of 3 -> fifo_flush_o and aborted_o pulse once, no done_o; a late acc_done_i is ignored; cmd_ready_o=1 the following cycle.
- Zero count: ktiles=0, otiles=5 -> no acc_start, no pop; done_o one cycle after acceptance.
- Reset mid-DEQ with deq_ready_i=1 asserted -> next cycle all outputs 0, no pop, no flush, cmd_ready_o=1 after rst deasserts.
